// File: rtl/bist_sequencer_if.sv
// Memory-under-test port of the BIST sequencer.
// mem_we/mem_re are single-cycle strobes, never high together; mem_rdata is valid the cycle after mem_re.
interface bist_sequencer_if #(
    parameter int AW = 8
);
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/bist_sequencer.sv
// JTAG-driven BIST engine: loads pattern words under GETTEST, replays them against the MUT under RUNBIST.
// Optional MISR signature compression is enabled by defining BIST_MISR_EN.
module bist_sequencer #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ir_gettest,
    input  logic                    ir_runbist,
    input  logic                    dr_upd_tgl,
    input  logic [9:0]              dr_word,
    bist_sequencer_if.master        mem,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    overflow,
    output logic [7:0]              err_count,
    output logic [AW-1:0]           fail_addr,
    output logic [7:0]              fail_data,
    output logic [15:0]             signature,
    output logic [2:0]              dbg_state
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    logic [2:0]    state;
    logic [1:0]    gt_sync, rb_sync, tg_sync;
    logic          gt_d, rb_d, tg_d;
    logic          gt_rise, rb_rise, rb_fall, upd;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          wr_full, last, abort, pat_we, run_start, chk_en;
    logic [9:0]    pat_mem [DEPTH];
    logic [9:0]    pat_q;
    logic [1:0]    op;
    logic [7:0]    operand;
    logic [AW-1:0] addr;

    // TCK-domain levels and the UPDATE_DR toggle cross via plain 2-flop synchronisers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_sync <= '0;
            rb_sync <= '0;
            tg_sync <= '0;
            gt_d    <= 1'b0;
            rb_d    <= 1'b0;
            tg_d    <= 1'b0;
        end else begin
            gt_sync <= {gt_sync[0], ir_gettest};
            rb_sync <= {rb_sync[0], ir_runbist};
            tg_sync <= {tg_sync[0], dr_upd_tgl};
            gt_d    <= gt_sync[1];
            rb_d    <= rb_sync[1];
            tg_d    <= tg_sync[1];
        end
    end

    assign gt_rise   = gt_sync[1] & ~gt_d;
    assign rb_rise   = rb_sync[1] & ~rb_d;
    assign rb_fall   = ~rb_sync[1] & rb_d;
    assign upd       = tg_sync[1] ^ tg_d;
    assign wr_full   = wr_ptr[PW];
    assign last      = (rd_ptr == wr_ptr);
    assign abort     = busy & rb_fall;
    assign pat_we    = (state == S_IDLE) & ~gt_rise & upd & gt_sync[1] & ~wr_full;
    assign run_start = (state == S_IDLE) & rb_rise;
    assign chk_en    = (state == S_CHECK) & ~abort;
    assign op        = pat_q[1:0];
    assign operand   = pat_q[9:2];

    // dr_word is stable from toggle to toggle, so it is sampled without synchronisation
    always_ff @(posedge clk) begin
        if (pat_we)
            pat_mem[wr_ptr[PW-1:0]] <= dr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pat_q <= '0;
        else if (state == S_FETCH)
            pat_q <= pat_mem[rd_ptr[PW-1:0]];
    end

    assign mem.mem_we    = (state == S_EXEC) & (op == OP_WRITE);
    assign mem.mem_re    = (state == S_EXEC) & (op == OP_READ);
    assign mem.mem_wdata = mem.mem_we ? operand : 8'h00;
    assign mem.mem_addr  = addr;
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gt_rise) begin
                        wr_ptr   <= '0;
                        overflow <= 1'b0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end else if (upd && gt_sync[1]) begin
                        if (!wr_full) wr_ptr   <= wr_ptr + 1'b1;
                        else          overflow <= 1'b1;
                    end
                    if (rb_rise) begin
                        err_count <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        rd_ptr    <= '0;
                        addr      <= '0;
                        busy      <= 1'b1;
                        state     <= (wr_ptr == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_WRITE: begin
                            addr  <= addr + 1'b1;
                            state <= last ? S_DONE : S_FETCH;
                        end
                        OP_LOAD: begin
                            addr  <= operand[AW-1:0];
                            state <= last ? S_DONE : S_FETCH;
                        end
                        OP_READ: state <= S_CHECK;
                        default: state <= S_DONE;
                    endcase
                end
                S_CHECK: begin
                    // address advances here so fail_addr records the address that was read
                    if (mem.mem_rdata != operand) begin
                        if (err_count != 8'hFF) err_count <= err_count + 1'b1;
                        if (err_count == 8'h00) begin
                            fail_addr <= addr;
                            fail_data <= mem.mem_rdata;
                        end
                    end
                    addr  <= addr + 1'b1;
                    state <= last ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == 8'h00);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BIST_MISR_EN
    // MISR over x^16+x^12+x^5+1, one {8'h00, rdata} word per CHECK cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            signature <= '0;
        else if (run_start)
            signature <= 16'hFFFF;
        else if (chk_en)
            signature <= {signature[14:0], 1'b0}
                       ^ (signature[15] ? 16'h1021 : 16'h0000)
                       ^ {8'h00, mem.mem_rdata};
    end
`else
    assign signature = 16'h0000;
    logic unused_misr;
    assign unused_misr = run_start & chk_en;
`endif
endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: JTAG-side driver tasks, MUT model, strobe scoreboard, summary report.
// Build with BIST_MISR_EN defined to check the MISR signature instead of the tied-off value.
module tb_bist_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       gt, rb, tgl, gt4, rb4, tgl4;
  logic [9:0] word, word4;
  logic       busy, done, pass, overflow, busy4, done4, pass4, overflow4;
  logic [7:0] err_count, fail_data, err_count4, fail_data4;
  logic [7:0] fail_addr, fail_addr4;
  logic [15:0] signature, signature4;
  logic [2:0] dbg_state, dbg_state4;

  bist_sequencer_if #(.AW(8)) mif ();
  bist_sequencer_if #(.AW(8)) mif4 ();

  bist_sequencer #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .ir_gettest(gt), .ir_runbist(rb), .dr_upd_tgl(tgl), .dr_word(word),
    .mem(mif), .busy(busy), .done(done), .pass(pass), .overflow(overflow), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data), .signature(signature), .dbg_state(dbg_state)
  );

  bist_sequencer #(.DEPTH(4), .AW(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .ir_gettest(gt4), .ir_runbist(rb4), .dr_upd_tgl(tgl4), .dr_word(word4),
    .mem(mif4), .busy(busy4), .done(done4), .pass(pass4), .overflow(overflow4), .err_count(err_count4),
    .fail_addr(fail_addr4), .fail_data(fail_data4), .signature(signature4), .dbg_state(dbg_state4)
  );

  // MUT model: synchronous write, registered read with optional bit-0 fault at address 3
  logic [7:0] mut [256];
  bit flip;
  always @(posedge clk) begin
    if (mif.mem_we) mut[mif.mem_addr] <= mif.mem_wdata;
    if (mif.mem_re) mif.mem_rdata <= mut[mif.mem_addr] ^ ((flip && mif.mem_addr == 8'd3) ? 8'h01 : 8'h00);
  end
  assign mif4.mem_rdata = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe is {we, addr, wdata-if-write}
  always @(negedge clk) begin
    if (rst_n && (mif.mem_we || mif.mem_re)) begin
      logic [16:0] obs;
      obs = {mif.mem_we, mif.mem_addr, mif.mem_we ? mif.mem_wdata : 8'h00};
      chk("we_re_exclusive", {31'b0, mif.mem_we & mif.mem_re}, 32'h0);
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL strobe_unexpected observed=%0h expected=none", obs);
      end
      if (exp_q.size() > 0) chk("strobe", {15'b0, obs}, {15'b0, exp_q.pop_front()});
    end
  end

  int w4_cnt;
  logic [7:0] w4_last;
  always @(negedge clk) begin
    if (mif4.mem_we) begin
      w4_cnt++;
      w4_last = mif4.mem_wdata;
    end
  end

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {8'h00, d};
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input bit d4, input logic [1:0] op, input logic [7:0] opd);
    if (d4) begin word4 = {opd, op}; tgl4 = ~tgl4; end
    else    begin word  = {opd, op}; tgl  = ~tgl;  end
    ticks(5);
  endtask

  task automatic gettest_entry(input bit d4);
    if (d4) gt4 = 1'b0; else gt = 1'b0;
    ticks(4);
    if (d4) gt4 = 1'b1; else gt = 1'b1;
    ticks(4);
  endtask

  task automatic run(input bit d4, output int busy_cycles, output int polls);
    if (d4) rb4 = 1'b1; else rb = 1'b1;
    ticks(2);
    busy_cycles = 0;
    polls = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      polls++;
      if (d4 ? busy4 : busy) busy_cycles++;
      if (d4 ? done4 : done) break;
    end
    chk("run_done", {31'b0, d4 ? done4 : done}, 32'h1);
    if (d4) rb4 = 1'b0; else rb = 1'b0;
    ticks(4);
  endtask

  task automatic load_test1_program();
    load(0, 2'b10, 8'h02); load(0, 2'b00, 8'hB1); load(0, 2'b00, 8'hF0); load(0, 2'b10, 8'h02);
    load(0, 2'b01, 8'hB1); load(0, 2'b01, 8'hF0); load(0, 2'b11, 8'h00);
  endtask

  task automatic push_test1_strobes();
    exp_q.push_back({1'b1, 8'h02, 8'hB1}); exp_q.push_back({1'b1, 8'h03, 8'hF0});
    exp_q.push_back({1'b0, 8'h02, 8'h00}); exp_q.push_back({1'b0, 8'h03, 8'h00});
  endtask

  // three writes, then a long LOAD run that gives the abort/reset time to land before the final WRITE
  task automatic load_abort_program();
    load(0, 2'b00, 8'hA1); load(0, 2'b00, 8'hA2); load(0, 2'b00, 8'hA3);
    for (int i = 0; i < 8; i++) load(0, 2'b10, 8'h00);
    load(0, 2'b00, 8'hEE); load(0, 2'b11, 8'h00);
    exp_q.push_back({1'b1, 8'h00, 8'hA1}); exp_q.push_back({1'b1, 8'h01, 8'hA2});
    exp_q.push_back({1'b1, 8'h02, 8'hA3});
  endtask

  task automatic wait_queue_empty(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 32'h0);
  endtask

  initial begin
    int bc, pl;
    logic [15:0] exp_sig;
    rst_n = 1'b0; gt = 0; rb = 0; tgl = 0; word = '0; gt4 = 0; rb4 = 0; tgl4 = 0; word4 = '0;
    flip = 0; w4_cnt = 0; w4_last = '0;
    ticks(3);
    chk("rst_busy", {31'b0, busy}, 0);       chk("rst_done", {31'b0, done}, 0);
    chk("rst_pass", {31'b0, pass}, 0);       chk("rst_overflow", {31'b0, overflow}, 0);
    chk("rst_err_count", {24'b0, err_count}, 0); chk("rst_signature", {16'b0, signature}, 0);
    chk("rst_mem_we_re", {30'b0, mif.mem_we, mif.mem_re}, 0); chk("rst_state", {29'b0, dbg_state}, 0);
    rst_n = 1'b1;
    ticks(2);

    // test 1: clean write/read run
    gettest_entry(0);
    load_test1_program();
    push_test1_strobes();
    run(0, bc, pl);
    chk("t1_busy_cycles", bc, 17);
    chk("t1_pass", {31'b0, pass}, 1);
    chk("t1_err_count", {24'b0, err_count}, 0);
    chk("t1_mut2", {24'b0, mut[2]}, 32'hB1);
    chk("t1_mut3", {24'b0, mut[3]}, 32'hF0);
    chk("t1_strobes_left", exp_q.size(), 0);
`ifdef BIST_MISR_EN
    exp_sig = misr_step(misr_step(16'hFFFF, 8'hB1), 8'hF0);
`else
    exp_sig = 16'h0000;
`endif
    chk("t1_signature", {16'b0, signature}, {16'b0, exp_sig});

    // test 2: same patterns, read of address 3 returns F1
    flip = 1;
    push_test1_strobes();
    run(0, bc, pl);
    flip = 0;
    chk("t2_err_count", {24'b0, err_count}, 1);
    chk("t2_fail_addr", {24'b0, fail_addr}, 3);
    chk("t2_fail_data", {24'b0, fail_data}, 32'hF1);
    chk("t2_pass", {31'b0, pass}, 0);

    // test 3: DEPTH=4 instance, fifth word dropped
    gettest_entry(1);
    load(1, 2'b00, 8'h11); load(1, 2'b00, 8'h22); load(1, 2'b00, 8'h33);
    load(1, 2'b00, 8'h44);
    chk("t3_no_overflow_at_4", {31'b0, overflow4}, 0);
    load(1, 2'b00, 8'h55);
    chk("t3_overflow", {31'b0, overflow4}, 1);
    w4_cnt = 0;
    run(1, bc, pl);
    chk("t3_write_count", w4_cnt, 4);
    chk("t3_last_write", {24'b0, w4_last}, 32'h44);
    chk("t3_pass", {31'b0, pass4}, 1);
    gettest_entry(1);
    chk("t3_overflow_cleared", {31'b0, overflow4}, 0);

    // test 5a: abort after the third op
    gettest_entry(0);
    load_abort_program();
    rb = 1'b1;
    wait_queue_empty("t5_abort_strobes");
    rb = 1'b0;
    ticks(5);
    chk("t5_abort_busy", {31'b0, busy}, 0);
    chk("t5_abort_done", {31'b0, done}, 0);
    chk("t5_abort_state", {29'b0, dbg_state}, 0);
    ticks(40);

    // test 5b: reset mid-run
    gettest_entry(0);
    load_abort_program();
    rb = 1'b1;
    wait_queue_empty("t5_reset_strobes");
    ticks(1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'b0, busy}, 0);
    chk("t5_rst_mem_we_re", {30'b0, mif.mem_we, mif.mem_re}, 0);
    chk("t5_rst_mem_addr", {24'b0, mif.mem_addr}, 0);
    chk("t5_rst_state", {29'b0, dbg_state}, 0);
    chk("t5_rst_err_signature", {8'b0, err_count, signature}, 0);
    rb = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(6);
    // wr_ptr cleared by reset: a run now issues no strobes
    run(0, bc, pl);
    chk("t5_post_reset_busy_cycles", bc, 1);
    chk("t5_post_reset_pass", {31'b0, pass}, 1);

    // test 4: GETTEST entry with no loads
    gettest_entry(0);
    run(0, bc, pl);
    chk("t4_done_latency_ok", {31'b0, pl <= 4}, 1);
    chk("t4_pass", {31'b0, pass}, 1);
    ticks(10);
    chk("t4_no_strobes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
